mips_dmem_dump_reader: RTL and testbench

- Synthesizable reader for the pipelined MIPS data memory. The core writes the data memory; this block reads it back.
- On request, it walks a contiguous address window through the memory's synchronous read port. Each word goes out on a valid/ready stream tagged with its address.
- Used by the bench and monitor to extract results after a program run without hierarchical peeking.

---
 rtl/mips_dmem_dump_reader.sv | 141 ++++++++++++++
 tb/tb_mips_dmem_dump_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_dump_reader.sv
// Streams a contiguous, wrapping window of the MIPS data memory out over a
// valid/ready interface, tagging each word with its address.
module mips_dmem_dump_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   issued_q;
  logic              infl_q;
  logic              infl_last_q;
  logic [ADDR_W-1:0] infl_addr_q;
  logic [ADDR_W-1:0] last_addr_q;

  logic [ADDR_W-1:0] faddr_q [2];
  logic [DATA_W-1:0] fdata_q [2];
  logic              flast_q [2];
  logic [1:0]        occ_q;

  logic [ADDR_W-1:0] faddr_d [2];
  logic [DATA_W-1:0] fdata_d [2];
  logic              flast_d [2];
  logic [1:0]        occ_d;

  logic              pop;
  logic              issue;
  logic [2:0]        level;
  logic [ADDR_W-1:0] rd_addr_now;

  // A read may issue only if the buffer can still absorb it after this
  // cycle's pop and the read already returning.
  always_comb begin
    pop         = (occ_q != 2'd0) && out_ready;
    level       = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    rd_addr_now = base_q + issued_q[ADDR_W-1:0];
    issue       = (state_q == S_RUN) && (issued_q < count_q) && (level < 3'd2);
  end

  always_comb begin
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    flast_d = flast_q;
    occ_d   = occ_q;
    if (pop) begin
      faddr_d[0] = faddr_q[1];
      fdata_d[0] = fdata_q[1];
      flast_d[0] = flast_q[1];
      occ_d      = occ_q - 2'd1;
    end
    if (infl_q) begin
      if (occ_d == 2'd0) begin
        faddr_d[0] = infl_addr_q;
        fdata_d[0] = mem_rd_data;
        flast_d[0] = infl_last_q;
      end else begin
        faddr_d[1] = infl_addr_q;
        fdata_d[1] = mem_rd_data;
        flast_d[1] = infl_last_q;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_addr_q <= '0;
      last_addr_q <= '0;
      occ_q       <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        faddr_q[i] <= '0;
        fdata_q[i] <= '0;
        flast_q[i] <= 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (dump_start) begin
          base_q   <= dump_base;
          count_q  <= dump_count;
          issued_q <= '0;
          state_q  <= (dump_count == '0) ? S_FIN : S_RUN;
        end
        S_RUN:  if (pop && flast_q[0]) state_q <= S_FIN;
        S_FIN:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (issue) begin
        issued_q    <= issued_q + CNT_ONE;
        last_addr_q <= rd_addr_now;
        infl_addr_q <= rd_addr_now;
        infl_last_q <= (issued_q + CNT_ONE == count_q);
      end
      infl_q <= issue;
      occ_q  <= occ_d;
      for (int unsigned i = 0; i < 2; i++) begin
        faddr_q[i] <= faddr_d[i];
        fdata_q[i] <= fdata_d[i];
        flast_q[i] <= flast_d[i];
      end
    end
  end

  always_comb begin
    busy        = (state_q == S_RUN);
    done        = (state_q == S_FIN);
    mem_rd_en   = issue;
    mem_rd_addr = issue ? rd_addr_now : last_addr_q;
    out_valid   = (occ_q != 2'd0);
    out_addr    = faddr_q[0];
    out_data    = fdata_q[0];
    out_last    = flast_q[0];
  end

endmodule

// File: tb/tb_mips_dmem_dump_reader.sv
// Bench for mips_dmem_dump_reader: directed scenarios plus randomized dumps
// against a queue-based model of the expected read and output sequences.
module tb_mips_dmem_dump_reader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dump_start = 1'b0;
  logic [AW-1:0] dump_base = '0;
  logic [AW:0]   dump_count = '0;
  logic          busy, done, mem_rd_en, out_valid, out_last;
  logic [AW-1:0] mem_rd_addr, out_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  mips_dmem_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .dump_start(dump_start), .dump_base(dump_base),
    .dump_count(dump_count), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  logic [DW-1:0] mem [1024];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int ready_mode = 0;
  int rphase = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = ((rphase % 3) == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
    rphase++;
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  word_t         exp_q[$];
  int unsigned   rd_q[$];
  int unsigned   seen_a[$];
  logic [DW-1:0] seen_d[$];
  bit            m_active = 0, m_done = 0, chk_reset = 1, prev_stall = 0;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_d;
  logic          s_l;
  int outst = 0, hs_cnt = 0, done_cnt = 0;

  // Model: at acceptance the whole dump is expanded into the expected read
  // address list and the expected output word list; the DUT must consume both.
  initial begin : compare
    bit          last_hs;
    word_t       w;
    int unsigned a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      last_hs = 0;
      if (chk_reset) begin
        chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);     chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_out_valid", out_valid, 0); chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);   chk("rst_out_last", out_last, 0);
      end
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (!m_active) begin
        chk("idle_rd_en", mem_rd_en, 0);
        chk("idle_out_valid", out_valid, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1); chk("stall_addr", out_addr, s_a);
        chk("stall_data", out_data, s_d); chk("stall_last", out_last, s_l);
      end
      if (mem_rd_en) begin
        outst++;
        if (rd_q.size() == 0) chk("rd_extra", mem_rd_en, 0);
        else chk("rd_addr", mem_rd_addr, rd_q.pop_front());
      end
      if (out_valid && out_ready) begin
        outst--;
        hs_cnt++;
        seen_a.push_back(out_addr);
        seen_d.push_back(out_data);
        if (exp_q.size() == 0) chk("word_extra", out_valid, 0);
        else begin
          w = exp_q.pop_front();
          chk("out_addr", out_addr, w.a);
          chk("out_data", out_data, w.d);
          chk("out_last", out_last, w.l);
          last_hs = w.l;
        end
      end
      if (mem_rd_en) chk("outstanding_le2", outst <= 2, 1);
      if (done) done_cnt++;
      #4;
      if (rst) begin
        exp_q.delete(); rd_q.delete();
        m_active = 0; m_done = 0; chk_reset = 1; prev_stall = 0; outst = 0;
      end else begin
        chk_reset  = 0;
        prev_stall = out_valid && !out_ready;
        s_a = out_addr; s_d = out_data; s_l = out_last;
        if (last_hs) begin
          m_active = 0; m_done = 1;
        end else if (!m_active && !m_done && dump_start) begin
          for (int i = 0; i < int'(dump_count); i++) begin
            a = (int'(dump_base) + i) % 1024;
            rd_q.push_back(a);
            exp_q.push_back('{a: a[AW-1:0], d: mem[a], l: (i == int'(dump_count) - 1)});
          end
          if (dump_count == 0) m_done = 1;
          else m_active = 1;
        end else begin
          m_done = 0;
        end
      end
    end
  end

  task automatic start(input int b, input int c);
    @(posedge clk); #1;
    dump_start = 1'b1; dump_base = b[AW-1:0]; dump_count = c[AW:0];
    @(posedge clk); #1;
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    chk(nm, done, 1);
  endtask

  initial begin : stim
    logic [DW-1:0] t1d [4];
    int h0, d0, c;
    t1d[0] = 32'd11; t1d[1] = 32'd22; t1d[2] = 32'd33; t1d[3] = 32'd44;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = t1d[i];
    mem[1022] = 32'hA; mem[1023] = 32'hB; mem[0] = 32'hC; mem[1] = 32'hD;
    for (int i = 0; i < 4; i++) mem[i] = t1d[i];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic dump with literal cycle expectations
    start(0, 4);
    for (int cy = 1; cy <= 8; cy++) begin
      @(negedge clk);
      chk($sformatf("t1_rd_en_c%0d", cy), mem_rd_en, (cy <= 4));
      chk($sformatf("t1_valid_c%0d", cy), out_valid, (cy >= 3 && cy <= 6));
      chk($sformatf("t1_done_c%0d", cy), done, (cy == 7));
      if (cy >= 3 && cy <= 6) begin
        chk("t1_addr", out_addr, cy - 3);
        chk("t1_data", out_data, t1d[cy-3]);
        chk("t1_last", out_last, (cy == 6));
      end
    end

    // Wrapping window
    mem[0] = 32'hC; mem[1] = 32'hD;
    seen_a.delete(); seen_d.delete();
    start(1022, 4);
    wait_done(40, "t2_done");
    chk("t2_count", seen_a.size(), 4);
    for (int i = 0; i < 4; i++) if (i < seen_a.size()) begin
      chk("t2_addr", seen_a[i], (1022 + i) % 1024);
      chk("t2_data", seen_d[i], 32'hA + i);
    end

    // Backpressure 1,0,0 pattern
    ready_mode = 1; rphase = 0;
    h0 = hs_cnt;
    start(40, 6);
    wait_done(100, "t3_done");
    chk("t3_handshakes", hs_cnt - h0, 6);
    ready_mode = 0;

    // Zero-length dump
    start(5, 0);
    @(negedge clk);
    chk("t4_done", done, 1); chk("t4_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_done_after", done, 0); chk("t4_busy_after", busy, 0);
      chk("t4_rd_en", mem_rd_en, 0); chk("t4_valid", out_valid, 0);
    end

    // Starts mid-dump and in the completion cycle are ignored
    h0 = hs_cnt; d0 = done_cnt;
    start(100, 5);
    @(posedge clk); #1;
    dump_start = 1'b1; dump_base = 10'd500; dump_count = 11'd3;
    @(posedge clk); #1 dump_start = 1'b0;
    wait_done(40, "t5_done");
    #1 dump_start = 1'b1; dump_base = 10'd700; dump_count = 11'd2;
    @(posedge clk); #1 dump_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_handshakes", hs_cnt - h0, 5);
    chk("t5_busy", busy, 0);
    h0 = hs_cnt;
    start(700, 2);
    wait_done(40, "t5_fresh_done");
    chk("t5_fresh_hs", hs_cnt - h0, 2);

    // Reset one cycle after the first read issues
    start(300, 8);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_stale", out_valid, 0);
    end
    h0 = hs_cnt;
    start(10, 3);
    wait_done(40, "t6_done");
    chk("t6_hs", hs_cnt - h0, 3);

    // Randomized dumps with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 10; k++) begin
      c = (k == 3) ? 1024 : (k == 5) ? 1 : $urandom_range(1, 40);
      h0 = hs_cnt;
      start($urandom_range(0, 1023), c);
      wait_done(10 * c + 60, "rand_done");
      chk("rand_hs", hs_cnt - h0, c);
    end
    repeat (3) @(negedge clk);
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_rd_empty", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
